mbe_r8_pp_select: RTL
=====================

Name: mbe_r8_pp_select

Overview:
- Sequential radix-8 Modified Booth encoder and partial-product selector for the mantissa multiplier.
- Sits directly downstream of the multiple generator, which supplies X, 2X, 3X and 4X.
- Captures one operand set, recodes the multiplier Y into radix-8 digits in {-4..+4}, and streams one signed partial product per beat to the accumulation stage over a valid/ready handshake.

Parameters:
- N, 23, mantissa MSB index; the multiplier is N+1 bits (hidden bit included).
- PPW, N+4, partial-product width. Localparam: two's complement, holds ±4X.
- NUM_PP, (N+6)/3, number of radix-8 digits. Localparam; 9 for N=23.
- IDXW, $clog2(NUM_PP), digit-index width. Localparam.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- x_default  in  N+3  X, zero-extended (26 bits).
- x_2x  in  N+3  2X.
- x_3x  in  N+3  3X.
- x_4x  in  N+3  4X.
- y  in  N+1  multiplier mantissa, unsigned.
- out_valid  out  1  pp/pp_idx/pp_last valid.
- out_ready  in  1  consumer accepts beat.
- pp  out  PPW  signed partial product for digit pp_idx; the consumer shifts it left by 3*pp_idx.
- pp_idx  out  IDXW  digit index 0..NUM_PP-1.
- pp_last  out  1  final beat of this operand set.

Behaviour:
- Reset: clock and reset are one clock, synchronous active-high reset (rst). On reset the FSM goes to IDLE and the index clears to 0. Outputs after reset: in_ready=1, out_valid=0, pp=0, pp_idx=0, pp_last=0.
- Reset mid-operation: reset asserted in EMIT abandons the set; the next cycle is IDLE with no further beats.
- FSM IDLE: in_ready=1, out_valid=0.
  - On in_valid, register the four multiples and Y zero-extended to 3*NUM_PP bits, with an implicit y[-1]=0.
  - Clear the index and go to EMIT.
- FSM EMIT: in_ready=0, out_valid=1.
  - When out_ready is high, the beat completes.
  - If pp_last, go to IDLE; otherwise increment the index.
- Inputs are ignored while not in IDLE.
- Latency and throughput:
  - Operand handshake at edge t; first beat valid in cycle t+1.
  - With out_ready held high: NUM_PP beats, then 1 IDLE cycle, so one operand set per NUM_PP+1 cycles.
- Stall: while out_valid=1 and out_ready=0, pp, pp_idx and pp_last hold stable.
- Outputs are functions of registered state only; there is no combinational path from in_* to out_*.
- Digit i uses bits b3..b0 = y[3i+2], y[3i+1], y[3i], y[3i-1], with digit = -4*b3 + 2*b2 + b1 + b0. Decode:
  - 0000 and 1111 → 0
  - 0001 and 0010 → +X
  - 0011 and 0100 → +2X
  - 0101 and 0110 → +3X
  - 0111 → +4X
  - 1000 → -4X
  - 1001 and 1010 → -3X
  - 1011 and 1100 → -2X
  - 1101 and 1110 → -X
- pp arithmetic: the selected multiple is zero-extended to PPW, then two's-complement negated when b3=1 and the digit is non-zero. A zero digit gives pp=0, never -0 artefacts.
- Sum invariant: the sum over i of pp_i*8^i equals X*Y exactly.
- pp_last = (index == NUM_PP-1).

Optional Feature:
- Macro: MBE_PP_ZERO_SKIP_EN.
- Defined:
  - Beats whose digit is 0 are not emitted, except the final digit NUM_PP-1, which is always emitted so that pp_last always terminates the set.
  - After each accepted beat, the index jumps to the next non-zero digit (priority search over the registered Y) or to NUM_PP-1.
  - The first beat is likewise the first non-zero digit or NUM_PP-1.
  - pp_idx still carries the true digit index.
- Undefined: all NUM_PP beats are emitted, as above.

Test Plan:
- Reset, idle: rst high 2 cycles → in_ready=1, out_valid=0, pp=0, pp_idx=0, pp_last=0.
- X=1, Y=1, out_ready=1 → 9 beats; pp_idx=0 has pp=1, idx1..8 have pp=0; pp_last only on idx 8. With MBE_PP_ZERO_SKIP_EN: 2 beats, (idx0, 1) then (idx8, 0, last).
- X=5, Y=24'hFFFFFF → idx0 pp=27'h7FFFFFB (-5); idx1..7 pp=0; idx8 pp=5. Reconstructed sum = 5*16777215.
- X=24'hFFFFFF, Y=3 → idx0 pp=27'h2FFFFFD (3X). Y=4 → idx0 = -4X = 27'h4000004, idx1 = 24'hFFFFFF. Y=7 → idx0 = -X, idx1 = +X.
- Stall and back-pressure: out_ready low 3 cycles at idx 4 → outputs held, no index advance. in_valid held high during EMIT → no capture; the next capture occurs only in IDLE, one cycle after the last handshake.
- Reset mid-operation: rst at idx 5 → next cycle out_valid=0, in_ready=1. The following operand set (X=1, Y=1) streams correctly from idx 0.
- Randomised check: 1000 random X/Y, each also under random out_ready; the sum of pp*8^idx equals X*Y in every case.

Source files
------------

// File: rtl/mbe_r8_pp_select_if.sv
// Operand/partial-product bus of the radix-8 Booth partial-product selector.
// Upstream it carries the multiples X, 2X, 3X and 4X and the multiplier Y
// with a valid/ready pair. Downstream it carries one signed partial product
// per beat with a valid/ready pair.
// The slave modport is the selector. The master modport is the side that
// feeds operands and consumes beats.
interface mbe_r8_pp_select_if #(
  parameter int N = 23
);
  localparam int PPW    = N + 4;
  localparam int NUM_PP = (N + 6) / 3;
  localparam int IDXW   = $clog2(NUM_PP);

  // Operand side
  logic            in_valid;
  logic            in_ready;
  logic [N+2:0]    x_default;
  logic [N+2:0]    x_2x;
  logic [N+2:0]    x_3x;
  logic [N+2:0]    x_4x;
  logic [N:0]      y;

  // Partial-product side
  logic            out_valid;
  logic            out_ready;
  logic [PPW-1:0]  pp;
  logic [IDXW-1:0] pp_idx;
  logic            pp_last;

  modport master (
    output in_valid, x_default, x_2x, x_3x, x_4x, y, out_ready,
    input  in_ready, out_valid, pp, pp_idx, pp_last
  );

  modport slave (
    input  in_valid, x_default, x_2x, x_3x, x_4x, y, out_ready,
    output in_ready, out_valid, pp, pp_idx, pp_last
  );
endinterface

// File: rtl/mbe_r8_pp_select.sv
// Sequential radix-8 Modified Booth encoder and partial-product selector.
// The block captures one operand set: the multiples X..4X and the multiplier
// Y. It recodes Y into radix-8 digits in {-4..+4}. It then emits one signed
// partial product per beat, and the consumer weights each beat by 8^pp_idx.
// Optional build macro MBE_PP_ZERO_SKIP_EN drops beats whose digit is zero.
// The last digit is always emitted, so pp_last always closes the set.
module mbe_r8_pp_select #(
  parameter int N = 23
) (
  input logic               clk,
  input logic               rst,
  mbe_r8_pp_select_if.slave bus
);
  localparam int PPW    = N + 4;
  localparam int NUM_PP = (N + 6) / 3;
  localparam int IDXW   = $clog2(NUM_PP);
  localparam int XW     = N + 3;
  // Y is zero-extended to 3*NUM_PP bits. One extra LSB holds the implicit y[-1]=0.
  localparam int YXW    = 3 * NUM_PP + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PP - 1);

  typedef enum logic {
    ST_IDLE,
    ST_EMIT
  } state_e;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_1X,
    SEL_2X,
    SEL_3X,
    SEL_4X
  } sel_e;

  typedef struct packed {
    sel_e sel;
    logic neg;
  } booth_t;

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [XW-1:0]   x1_q, x1_d;
  logic [XW-1:0]   x2_q, x2_d;
  logic [XW-1:0]   x3_q, x3_d;
  logic [XW-1:0]   x4_q, x4_d;
  logic [YXW-1:0]  yx_q, yx_d;

  logic            is_last;
  booth_t          booth;
  logic [PPW-1:0]  mag;

  // Radix-8 Booth decode of the window {y[3i+2], y[3i+1], y[3i], y[3i-1]}.
  // The sign is cleared on a zero digit, so a zero digit can never produce
  // a negated zero.
  function automatic booth_t decode(input logic [3:0] b);
    booth_t d;
    d.sel = SEL_ZERO;
    d.neg = b[3];
    case (b)
      4'b0001, 4'b0010: d.sel = SEL_1X;
      4'b0011, 4'b0100: d.sel = SEL_2X;
      4'b0101, 4'b0110: d.sel = SEL_3X;
      4'b0111:          d.sel = SEL_4X;
      4'b1000:          d.sel = SEL_4X;
      4'b1001, 4'b1010: d.sel = SEL_3X;
      4'b1011, 4'b1100: d.sel = SEL_2X;
      4'b1101, 4'b1110: d.sel = SEL_1X;
      default:          d.sel = SEL_ZERO;
    endcase
    if (d.sel == SEL_ZERO) d.neg = 1'b0;
    return d;
  endfunction

  // Four-bit recoding window for digit i of the extended multiplier.
  function automatic logic [3:0] window(input logic [YXW-1:0] yx,
                                        input logic [IDXW-1:0] i);
    return yx[3 * int'(i) +: 4];
  endfunction

`ifdef MBE_PP_ZERO_SKIP_EN
  // Finds the lowest digit index >= start whose digit is non-zero.
  // If there is none, it returns the last digit. The loop runs downward,
  // so the lowest hit is written last and wins.
  function automatic logic [IDXW-1:0] first_nz(input logic [YXW-1:0] yx,
                                               input int start);
    logic [IDXW-1:0] hit;
    logic [3:0]      b;
    hit = LAST_IDX;
    for (int i = NUM_PP - 2; i >= 0; i--) begin
      b = yx[3*i +: 4];
      if (i >= start && b != 4'b0000 && b != 4'b1111) hit = IDXW'(i);
    end
    return hit;
  endfunction
`endif

  assign is_last = (idx_q == LAST_IDX);

  // Next-state logic, operand capture and handshake outputs of the IDLE/EMIT FSM.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    idx_d         = idx_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    x3_d          = x3_q;
    x4_d          = x4_q;
    yx_d          = yx_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          x1_d    = bus.x_default;
          x2_d    = bus.x_2x;
          x3_d    = bus.x_3x;
          x4_d    = bus.x_4x;
          yx_d    = YXW'({bus.y, 1'b0});
`ifdef MBE_PP_ZERO_SKIP_EN
          idx_d   = first_nz(YXW'({bus.y, 1'b0}), 0);
`else
          idx_d   = '0;
`endif
          state_d = ST_EMIT;
        end
      end

      ST_EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (is_last) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
`ifdef MBE_PP_ZERO_SKIP_EN
            idx_d = first_nz(yx_q, int'(idx_q) + 1);
`else
            idx_d = idx_q + 1'b1;
`endif
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Partial-product datapath: select the multiple, then negate it for negative digits.
  always_comb begin
    booth = decode(window(yx_q, idx_q));
    mag   = '0;
    case (booth.sel)
      SEL_1X:  mag = PPW'(x1_q);
      SEL_2X:  mag = PPW'(x2_q);
      SEL_3X:  mag = PPW'(x3_q);
      SEL_4X:  mag = PPW'(x4_q);
      default: mag = '0;
    endcase

    // The operand registers are not reset, so pp is forced to zero outside EMIT.
    bus.pp = '0;
    if (state_q == ST_EMIT) bus.pp = booth.neg ? (~mag + 1'b1) : mag;
    bus.pp_idx  = idx_q;
    bus.pp_last = (state_q == ST_EMIT) && is_last;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand registers. They are only loaded in IDLE and only read in EMIT.
  always_ff @(posedge clk) begin
    // NOTE: data registers are deliberately left without reset; the FSM never reads them before a capture.
    x1_q <= x1_d;
    x2_q <= x2_d;
    x3_q <= x3_d;
    x4_q <= x4_d;
    yx_q <= yx_d;
  end
endmodule
